// File: rtl/chi_link_pkg.sv
// Shared definitions for the CHI link-layer receive path: link state
// encoding, credit ceiling and the credit-return opcode.
package chi_link_pkg;

  typedef enum logic [1:0] {
    STOP       = 2'd0,
    ACTIVATE   = 2'd1,
    RUN        = 2'd2,
    DEACTIVATE = 2'd3
  } link_state_e;

  // Largest L-credit count the link layer can hold outstanding.
  localparam int LCRD_MAX = 15;

  // Opcode value that marks an L-credit-return flit.
  localparam int OPC_LCRDRETURN = 0;

endpackage

// File: rtl/chi_link_rx_if.sv
// Inbound CHI channel bundle: the transmitter-facing link signals plus the
// valid/ready stream toward the home-node logic. The receiver uses the
// slave modport; the transmitter/consumer side uses master.
interface chi_link_rx_if #(
  parameter int FLIT_W = 128
) ();

  logic              rx_linkactivereq;
  logic              rx_linkactiveack;
  logic              rx_flitpend;
  logic              rx_flitv;
  logic [FLIT_W-1:0] rx_flit;
  logic              rx_lcrdv;
  logic              out_valid;
  logic              out_ready;
  logic [FLIT_W-1:0] out_flit;

  modport master (
    output rx_linkactivereq,
    output rx_flitpend,
    output rx_flitv,
    output rx_flit,
    output out_ready,
    input  rx_linkactiveack,
    input  rx_lcrdv,
    input  out_valid,
    input  out_flit
  );

  modport slave (
    input  rx_linkactivereq,
    input  rx_flitpend,
    input  rx_flitv,
    input  rx_flit,
    input  out_ready,
    output rx_linkactiveack,
    output rx_lcrdv,
    output out_valid,
    output out_flit
  );

endinterface

// File: rtl/chi_link_fifo.sv
// Synchronous FIFO with modulo-DEPTH pointers (DEPTH need not be a power of
// two). Callers guarantee no push when full and no pop when empty; the
// credit scheme upstream makes overflow impossible.
module chi_link_fifo #(
  parameter  int W     = 128,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage write.
  // NOTE: the array has no reset; pointers and count define what is valid,
  // and resetting wide storage only costs flops and routing.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/chi_link_rx.sv
// CHI link-layer receiver for one inbound channel: link-activation FSM,
// L-credit issue and tracking, credit-return absorption, flit buffering and
// a sticky error flag for flits that arrive without a credit.
module chi_link_rx
  import chi_link_pkg::*;
#(
  parameter  int FLIT_W  = 128,
  parameter  int DEPTH   = 4,
  parameter  int OPC_LSB = 28,
  parameter  int OPC_W   = 7,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  chi_link_rx_if.slave  bus,
  output logic [CW-1:0] crd_out,
  output link_state_e   link_state,
  output logic          err
);

  if (DEPTH < 1 || DEPTH > LCRD_MAX) begin : g_bad_depth
    $error("chi_link_rx: DEPTH must be within 1..LCRD_MAX");
  end

  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  link_state_e       state;
  link_state_e       state_nxt;
  logic              ack;
  logic [CW-1:0]     crd;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       used;
  logic              issue;
  logic              lcrdv_q;
  logic              take;
  logic              is_ret;
  logic              push;
  logic              pop;
  logic              valid;
  logic              err_q;
  logic [OPC_W-1:0]  opcode;
  logic [FLIT_W-1:0] head;
  logic              unused_flitpend;

  assign unused_flitpend = bus.rx_flitpend;

  assign opcode = bus.rx_flit[OPC_LSB +: OPC_W];
  assign is_ret = (opcode == OPC_W'(OPC_LCRDRETURN));

  // A flit is only honoured when the transmitter actually holds a credit.
  assign take  = bus.rx_flitv && (crd != '0);
  assign push  = take && !is_ret;
  assign valid = (fifo_count != '0);
  assign pop   = valid && bus.out_ready;

  // Credits plus buffered flits never exceed DEPTH, so the FIFO cannot
  // overflow. The request term stops issue as soon as deactivation starts.
  assign used  = {1'b0, crd} + {1'b0, fifo_count};
  assign issue = (state == RUN) && bus.rx_linkactivereq && (used < DEPTH_W);

  // Link-state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= STOP;
    else       state <= state_nxt;
  end

  // Next-state and acknowledge decode.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    ack       = 1'b1;
    case (state)
      STOP: begin
        ack = 1'b0;
        if (bus.rx_linkactivereq) state_nxt = ACTIVATE;
      end
      ACTIVATE:   state_nxt = RUN;
      RUN:        if (!bus.rx_linkactivereq) state_nxt = DEACTIVATE;
      DEACTIVATE: if (crd == '0) state_nxt = STOP;
      default:    state_nxt = STOP;
    endcase
  end

  // Outstanding-credit counter and registered credit grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crd     <= '0;
      lcrdv_q <= 1'b0;
    end else begin
      lcrdv_q <= issue;
      if (issue && !take)      crd <= crd + 1'b1;
      else if (take && !issue) crd <= crd - 1'b1;
    end
  end

  // Sticky protocol error: a flit with no credit held by the transmitter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          err_q <= 1'b0;
    else if (bus.rx_flitv && crd == '0) err_q <= 1'b1;
  end

  chi_link_fifo #(
    .W     (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (bus.rx_flit),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign bus.rx_linkactiveack = ack;
  assign bus.rx_lcrdv         = lcrdv_q;
  assign bus.out_valid        = valid;
  assign bus.out_flit         = valid ? head : '0;
  assign crd_out              = crd;
  assign link_state           = state;
  assign err                  = err_q;

endmodule
